// File: rtl/core_sequencer.sv
// core_sequencer: decodes each 19-bit instruction into a control word.
// It gates all architectural side effects through one commit qualifier.
// It tracks the branch zero flag, a return-stack depth shadow and a retired count.
// It sequences free-run, single-step, HALT and fault stop.
//
// Ports:
//   clk, rst_n            clock (rising edge) and async active-low reset
//   instruction[18:0]     instruction at current pc
//   zero                  ALU zero result of this cycle
//   stack_overflow        overflow from the return stack (faults)
//   run, step_req         debug/run control (level / request)
//   step_ack              high in the cycle a stepped instruction commits
//   halted, fault         HALT / FAULT state indicators
//   pc_write              commit strobe; pc/reg/mem/stack update on this edge
//   reg_write_signal, mem_read_write, stack_push, stack_pop, pc_src
//                         side-effect controls, forced inactive without commit
//   mem_or_alu, is_shift, alu_src, reg2_read_source, scode, acode
//                         decode-only fields, follow instruction
//   retired[RET_W-1:0]    committed-instruction count (wraps)
module core_sequencer #(
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned RET_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [18:0]      instruction,
  input  logic             zero,
  input  logic             stack_overflow,
  input  logic             run,
  input  logic             step_req,
  output logic             step_ack,
  output logic             halted,
  output logic             fault,
  output logic             pc_write,
  output logic             reg_write_signal,
  output logic             mem_read_write,
  output logic             mem_or_alu,
  output logic             is_shift,
  output logic             alu_src,
  output logic             reg2_read_source,
  output logic             stack_push,
  output logic             stack_pop,
  output logic [1:0]       pc_src,
  output logic [1:0]       scode,
  output logic [2:0]       acode,
  output logic [RET_W-1:0] retired
);

  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STEP  = 3'd1,
    S_RUN   = 3'd2,
    S_HALT  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic               zflag_q;
  logic [DEPTH_W-1:0] depth_q;
  logic [RET_W-1:0]   retired_q;

  // Ungated decode results
  logic       dec_reg_write;
  logic       dec_mem_write;
  logic       dec_push;
  logic       dec_pop;
  logic [1:0] dec_pc_src;
  logic       dec_sets_zflag;
  logic       dec_jal;
  logic       dec_ret;
  logic       dec_halt;

  logic would_commit_c;
  logic fault_c;
  logic commit_c;

  logic [1:0] op;
  logic [2:0] sub;
  assign op  = instruction[18:17];
  assign sub = instruction[16:14];

  // Operand fields are consumed by the data path, not here
  logic unused_instr_bits;
  assign unused_instr_bits = ^instruction[13:0];

  // Instruction decode
  always_comb begin
    dec_reg_write    = 1'b0;
    dec_mem_write    = 1'b0;
    dec_push         = 1'b0;
    dec_pop          = 1'b0;
    dec_pc_src       = 2'b00;
    dec_sets_zflag   = 1'b0;
    dec_jal          = 1'b0;
    dec_ret          = 1'b0;
    dec_halt         = 1'b0;
    mem_or_alu       = 1'b0;
    is_shift         = 1'b0;
    alu_src          = 1'b0;
    reg2_read_source = 1'b0;
    scode            = 2'b00;
    acode            = 3'b000;
    case (op)
      2'b00, 2'b01: begin
        acode          = sub;
        dec_reg_write  = 1'b1;
        mem_or_alu     = 1'b1;
        alu_src        = op[0];
        dec_sets_zflag = 1'b1;
      end
      2'b10: begin
        if (sub[2]) begin
          is_shift       = 1'b1;
          scode          = sub[1:0];
          dec_reg_write  = 1'b1;
          mem_or_alu     = 1'b1;
          dec_sets_zflag = 1'b1;
        end else if (sub[1]) begin
          alu_src          = 1'b1;
          reg2_read_source = 1'b1;
          dec_mem_write    = 1'b1;
        end else begin
          alu_src       = 1'b1;
          dec_reg_write = 1'b1;
        end
      end
      default: begin
        case (sub)
          3'b000: dec_pc_src = 2'b01;
          3'b001: begin
            dec_pc_src = 2'b01;
            dec_push   = 1'b1;
            dec_jal    = 1'b1;
          end
          3'b010: begin
            dec_pc_src = 2'b10;
            dec_pop    = 1'b1;
            dec_ret    = 1'b1;
          end
          3'b011:  dec_pc_src = zflag_q ? 2'b11 : 2'b00;
          3'b100:  dec_pc_src = zflag_q ? 2'b00 : 2'b11;
          3'b111:  dec_halt   = 1'b1;
          default: dec_pc_src = 2'b00;
        endcase
      end
    endcase
  end

  // Commit qualification: a fault blocks the would-be commit
  assign would_commit_c = (state_q == S_RUN) || (state_q == S_STEP);
  assign fault_c  = would_commit_c &&
                    (stack_overflow ||
                     (dec_jal && (depth_q == DEPTH_MAX)) ||
                     (dec_ret && (depth_q == '0)));
  assign commit_c = would_commit_c && !fault_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and gated outputs
  always_comb begin
    state_d          = state_q;
    pc_write         = 1'b0;
    reg_write_signal = 1'b0;
    mem_read_write   = 1'b0;
    stack_push       = 1'b0;
    stack_pop        = 1'b0;
    pc_src           = 2'b00;
    step_ack         = 1'b0;
    halted           = (state_q == S_HALT);
    fault            = (state_q == S_FAULT);

    if (commit_c) begin
      pc_write         = 1'b1;
      reg_write_signal = dec_reg_write;
      mem_read_write   = dec_mem_write;
      stack_push       = dec_push;
      stack_pop        = dec_pop;
      pc_src           = dec_pc_src;
    end

    case (state_q)
      S_IDLE: begin
        if (run)           state_d = S_RUN;
        else if (step_req) state_d = S_STEP;
      end
      S_STEP: begin
        step_ack = commit_c;
        if (fault_c)       state_d = S_FAULT;
        else if (dec_halt) state_d = S_HALT;
        else               state_d = S_IDLE;
      end
      S_RUN: begin
        if (fault_c)       state_d = S_FAULT;
        else if (dec_halt) state_d = S_HALT;
        else if (!run)     state_d = S_IDLE;
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // Architectural shadows: zero flag, stack depth, retired count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zflag_q   <= 1'b0;
      depth_q   <= '0;
      retired_q <= '0;
    end else if (commit_c) begin
      retired_q <= retired_q + RET_W'(1);
      if (dec_sets_zflag) zflag_q <= zero;
      if (dec_jal)        depth_q <= depth_q + DEPTH_W'(1);
      else if (dec_ret)   depth_q <= depth_q - DEPTH_W'(1);
    end
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: run, step, branches, stack faults, HALT, reset.
module tb_core_sequencer;

  localparam int unsigned RET_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [18:0]      instruction;
  logic             zero, stack_overflow, run, step_req;
  logic             step_ack, halted, fault, pc_write, reg_write_signal;
  logic             mem_read_write, mem_or_alu, is_shift, alu_src, reg2_read_source;
  logic             stack_push, stack_pop;
  logic [1:0]       pc_src, scode;
  logic [2:0]       acode;
  logic [RET_W-1:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [18:0] I_ALU  = 19'h00000;
  localparam logic [18:0] I_ALU5 = {2'b00, 3'b101, 14'h0};
  localparam logic [18:0] I_SW   = {4'b1001, 15'h0};
  localparam logic [18:0] I_BZ   = {2'b11, 3'b011, 6'h0, 8'hFE};
  localparam logic [18:0] I_BNZ  = {2'b11, 3'b100, 6'h0, 8'hFE};
  localparam logic [18:0] I_JAL  = {2'b11, 3'b001, 14'h0};
  localparam logic [18:0] I_RET  = {2'b11, 3'b010, 14'h0};
  localparam logic [18:0] I_NOP  = {2'b11, 3'b101, 14'h0};
  localparam logic [18:0] I_HALT = {2'b11, 3'b111, 14'h0};

  core_sequencer #(.STACK_DEPTH(8), .RET_W(RET_W)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .zero(zero),
    .stack_overflow(stack_overflow), .run(run), .step_req(step_req),
    .step_ack(step_ack), .halted(halted), .fault(fault), .pc_write(pc_write),
    .reg_write_signal(reg_write_signal), .mem_read_write(mem_read_write),
    .mem_or_alu(mem_or_alu), .is_shift(is_shift), .alu_src(alu_src),
    .reg2_read_source(reg2_read_source), .stack_push(stack_push),
    .stack_pop(stack_pop), .pc_src(pc_src), .scode(scode), .acode(acode),
    .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    step_req = 1'b0;
    stack_overflow = 1'b0;
    zero = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; step_req = 1'b0; zero = 1'b0;
    stack_overflow = 1'b0; instruction = I_ALU5;
    #3;
    // Reset state: gated outputs low, decode fields follow instruction
    check("rst_pc_write", 32'(pc_write), 32'd0);
    check("rst_reg_write", 32'(reg_write_signal), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_acode", 32'(acode), 32'd5);
    check("rst_mem_or_alu", 32'(mem_or_alu), 32'd1);
    tick(); tick();
    rst_n = 1'b1;

    // 1. Free run of ALU ops
    instruction = I_ALU; run = 1'b1; #1;
    check("t1_idle_pc_write", 32'(pc_write), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("t1_pc_write", 32'(pc_write), 32'd1);
      check("t1_reg_write", 32'(reg_write_signal), 32'd1);
      check("t1_retired", 32'(retired), 32'(i));
      tick();
    end
    run = 1'b0; #1;
    check("t1_last_commit", 32'(pc_write), 32'd1);
    tick();
    check("t1_stop_pc_write", 32'(pc_write), 32'd0);
    check("t1_stop_retired", 32'(retired), 32'd4);

    // 2. Single step of a store
    instruction = I_SW; step_req = 1'b1; #1;
    check("t2_idle_alu_src", 32'(alu_src), 32'd1);
    check("t2_idle_mem_write", 32'(mem_read_write), 32'd0);
    tick();
    step_req = 1'b0; #1;
    check("t2_mem_write", 32'(mem_read_write), 32'd1);
    check("t2_step_ack", 32'(step_ack), 32'd1);
    check("t2_reg2_src", 32'(reg2_read_source), 32'd1);
    check("t2_reg_write", 32'(reg_write_signal), 32'd0);
    tick();
    check("t2_ack_drop", 32'(step_ack), 32'd0);
    check("t2_mem_write_drop", 32'(mem_read_write), 32'd0);
    check("t2_retired", 32'(retired), 32'd5);

    // Held step_req: one commit per two cycles
    instruction = I_NOP; step_req = 1'b1;
    tick();
    check("t2h_ack", 32'(step_ack), 32'd1);
    tick();
    check("t2h_idle_pc_write", 32'(pc_write), 32'd0);
    tick(); tick();
    check("t2h_retired", 32'(retired), 32'd7);
    // run beats step_req in IDLE
    run = 1'b1;
    tick();
    check("t2r_step_ack", 32'(step_ack), 32'd0);
    check("t2r_pc_write", 32'(pc_write), 32'd1);
    step_req = 1'b0;

    // 3. Branches use the flag from the last committed ALU op
    instruction = I_ALU; zero = 1'b1;
    tick();
    instruction = I_BZ; zero = 1'b0; #1;
    check("t3_bz_taken", 32'(pc_src), 32'd3);
    check("t3_bz_pc_write", 32'(pc_write), 32'd1);
    instruction = I_BNZ; #1;
    check("t3_bnz_not_taken", 32'(pc_src), 32'd0);
    instruction = I_ALU; zero = 1'b0;
    tick();
    instruction = I_BZ; zero = 1'b1; #1;
    check("t3_bz_not_taken", 32'(pc_src), 32'd0);
    instruction = I_BNZ; #1;
    check("t3_bnz_taken", 32'(pc_src), 32'd3);
    check("t3_retired", 32'(retired), 32'd9);

    // 4. Eight JALs fill the stack; the ninth faults
    instruction = I_JAL; zero = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("t4_push", 32'(stack_push), 32'd1);
      check("t4_pc_src", 32'(pc_src), 32'd1);
      tick();
    end
    #1;
    check("t4_ovf_pc_write", 32'(pc_write), 32'd0);
    check("t4_ovf_push", 32'(stack_push), 32'd0);
    check("t4_ovf_pc_src", 32'(pc_src), 32'd0);
    check("t4_ovf_fault_pre", 32'(fault), 32'd0);
    check("t4_ovf_retired", 32'(retired), 32'd17);
    tick();
    check("t4_fault", 32'(fault), 32'd1);
    check("t4_fault_retired", 32'(retired), 32'd17);
    check("t4_fault_pc_write", 32'(pc_write), 32'd0);

    // JAL, RET, then RET at depth 0 faults
    do_reset();
    check("t4r_fault_cleared", 32'(fault), 32'd0);
    instruction = I_JAL; run = 1'b1;
    tick();
    check("t4r_jal_push", 32'(stack_push), 32'd1);
    tick();
    instruction = I_RET; #1;
    check("t4r_ret_pop", 32'(stack_pop), 32'd1);
    check("t4r_ret_pc_src", 32'(pc_src), 32'd2);
    tick();
    check("t4r_und_pc_write", 32'(pc_write), 32'd0);
    check("t4r_und_pop", 32'(stack_pop), 32'd0);
    tick();
    check("t4r_und_fault", 32'(fault), 32'd1);
    check("t4r_und_retired", 32'(retired), 32'd2);

    // stack_overflow input faults any would-commit cycle
    do_reset();
    instruction = I_ALU; run = 1'b1;
    tick();
    stack_overflow = 1'b1; #1;
    check("t4o_pc_write", 32'(pc_write), 32'd0);
    check("t4o_reg_write", 32'(reg_write_signal), 32'd0);
    tick();
    check("t4o_fault", 32'(fault), 32'd1);
    check("t4o_retired", 32'(retired), 32'd0);

    // 5. HALT commits, then nothing does
    do_reset();
    instruction = I_HALT; run = 1'b1;
    tick();
    check("t5_halt_commit", 32'(pc_write), 32'd1);
    check("t5_halted_pre", 32'(halted), 32'd0);
    tick();
    check("t5_halted", 32'(halted), 32'd1);
    check("t5_halt_pc_write", 32'(pc_write), 32'd0);
    step_req = 1'b1;
    tick();
    check("t5_still_halted", 32'(halted), 32'd1);
    check("t5_no_commit", 32'(pc_write), 32'd0);
    check("t5_retired", 32'(retired), 32'd1);

    // 6. Asynchronous reset mid-run
    do_reset();
    instruction = I_ALU; zero = 1'b1; run = 1'b1;
    tick(); tick(); tick();
    check("t6_pre_retired", 32'(retired), 32'd2);
    #3;
    rst_n = 1'b0; #1;
    check("t6_async_pc_write", 32'(pc_write), 32'd0);
    check("t6_async_reg_write", 32'(reg_write_signal), 32'd0);
    check("t6_async_retired", 32'(retired), 32'd0);
    tick();
    rst_n = 1'b1; run = 1'b0; instruction = I_BZ; #1;
    check("t6_idle_pc_write", 32'(pc_write), 32'd0);
    run = 1'b1;
    tick();
    check("t6_zflag_cleared", 32'(pc_src), 32'd0);
    check("t6_run_pc_write", 32'(pc_write), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
